// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline stall controller: register-address width,
// stall bus layout and a helper that builds monotone stall vectors.
package pipeline_ctrl_pkg;

    localparam int REG_ADDR_BUS_WIDTH = 5;
    localparam int STALL_BUS_WIDTH    = 6;

    // Stage index of each bit in the stall bus
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    typedef logic [STALL_BUS_WIDTH-1:0] stall_vec_t;

    // Stall every stage from PC up to and including 'stage'; the result is
    // monotone by construction, so the bubble lands at stage+1.
    function automatic stall_vec_t stall_through(input int stage);
        stall_vec_t vec;
        vec = '0;
        for (int i = 0; i < STALL_BUS_WIDTH; i++) begin
            if (i <= stage) begin
                vec[i] = 1'b1;
            end
        end
        return vec;
    endfunction

endpackage

// File: rtl/multicycle_tracker.sv
// Tracks a multi-cycle EX operation: stalls EX for exactly N cycles, then
// presents ex_done until the instruction can leave EX (no MEM stall).
module multicycle_tracker #(
    parameter int EX_CNT_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ex_start,
    input  logic [EX_CNT_WIDTH-1:0] ex_cycles,
    input  logic                    mem_stall,
    output logic                    ex_stall,
    output logic                    ex_done,
    output logic                    ex_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t                  state;
    logic [EX_CNT_WIDTH-1:0] cnt;
    logic                    accept;

    // A zero-length request is a single-cycle op and never enters the FSM
    assign accept   = (state == IDLE) && ex_start && (ex_cycles != '0);
    // The start cycle itself already counts as the first stalled cycle
    assign ex_stall = accept || (state == BUSY);

    // FSM with counter; ex_done/ex_busy are registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            ex_done <= 1'b0;
            ex_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ex_busy <= 1'b1;
                        if (ex_cycles == EX_CNT_WIDTH'(1)) begin
                            state   <= DONE;
                            ex_done <= 1'b1;
                        end else begin
                            state <= BUSY;
                            cnt   <= ex_cycles - EX_CNT_WIDTH'(2);
                        end
                    end
                end
                BUSY: begin
                    // Keeps counting even while MEM holds the pipeline
                    if (cnt == '0) begin
                        state   <= DONE;
                        ex_done <= 1'b1;
                    end else begin
                        cnt <= cnt - EX_CNT_WIDTH'(1);
                    end
                end
                DONE: begin
                    // Result must stay valid until the instruction can move on
                    if (!mem_stall) begin
                        state   <= IDLE;
                        ex_done <= 1'b0;
                        ex_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ex_done <= 1'b0;
                    ex_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall controller: merges MEM wait, multi-cycle EX and load-use
// hazards into one monotone stall vector and counts front-end stall cycles.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int EX_CNT_WIDTH   = 5,
    parameter int PERF_CNT_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_read_en_1,
    input  logic [REG_ADDR_BUS_WIDTH-1:0] id_read_addr_1,
    input  logic                          id_read_en_2,
    input  logic [REG_ADDR_BUS_WIDTH-1:0] id_read_addr_2,
    input  logic                          ex_ram_read_flag,
    input  logic                          ex_write_reg_en,
    input  logic [REG_ADDR_BUS_WIDTH-1:0] ex_write_reg_addr,
    input  logic                          ex_start,
    input  logic [EX_CNT_WIDTH-1:0]       ex_cycles,
    input  logic                          mem_ram_ready,
    input  logic                          mem_ram_en,
    output logic [STALL_BUS_WIDTH-1:0]    stall,
    output logic                          ex_done,
    output logic                          ex_busy,
    output logic [PERF_CNT_WIDTH-1:0]     stall_cycles
);

    logic mem_stall;
    logic ex_stall;
    logic load_use;
    logic hit_1;
    logic hit_2;

    assign mem_stall = mem_ram_en && !mem_ram_ready;

    // r0 is hard-wired zero, so a load targeting it never creates a hazard
    assign hit_1    = id_read_en_1 && (id_read_addr_1 == ex_write_reg_addr);
    assign hit_2    = id_read_en_2 && (id_read_addr_2 == ex_write_reg_addr);
    assign load_use = ex_ram_read_flag && ex_write_reg_en &&
                      (ex_write_reg_addr != '0) && (hit_1 || hit_2);

    multicycle_tracker #(
        .EX_CNT_WIDTH(EX_CNT_WIDTH)
    ) u_tracker (
        .clk       (clk),
        .rst       (rst),
        .ex_start  (ex_start),
        .ex_cycles (ex_cycles),
        .mem_stall (mem_stall),
        .ex_stall  (ex_stall),
        .ex_done   (ex_done),
        .ex_busy   (ex_busy)
    );

    // Fixed-priority stall mux; the deepest stalled stage wins
    always_comb begin
        stall = '0;
        if (!rst) begin
            if (mem_stall) begin
                stall = stall_through(STALL_MEM);
            end else if (ex_stall) begin
                stall = stall_through(STALL_EX);
            end else if (load_use) begin
                stall = stall_through(STALL_ID);
            end
        end
    end

    // Performance counter of cycles in which the PC is held; wraps freely
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall[STALL_PC]) begin
            stall_cycles <= stall_cycles + PERF_CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a 4-bit stall counter.
module tb_pipeline_ctrl;

    logic       clk;
    logic       rst;
    logic       id_read_en_1;
    logic [4:0] id_read_addr_1;
    logic       id_read_en_2;
    logic [4:0] id_read_addr_2;
    logic       ex_ram_read_flag;
    logic       ex_write_reg_en;
    logic [4:0] ex_write_reg_addr;
    logic       ex_start;
    logic [4:0] ex_cycles;
    logic       mem_ram_ready;
    logic       mem_ram_en;
    logic [5:0] stall;
    logic       ex_done;
    logic       ex_busy;
    logic [3:0] stall_cycles;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    pipeline_ctrl #(
        .EX_CNT_WIDTH   (5),
        .PERF_CNT_WIDTH (4)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .id_read_en_1      (id_read_en_1),
        .id_read_addr_1    (id_read_addr_1),
        .id_read_en_2      (id_read_en_2),
        .id_read_addr_2    (id_read_addr_2),
        .ex_ram_read_flag  (ex_ram_read_flag),
        .ex_write_reg_en   (ex_write_reg_en),
        .ex_write_reg_addr (ex_write_reg_addr),
        .ex_start          (ex_start),
        .ex_cycles         (ex_cycles),
        .mem_ram_ready     (mem_ram_ready),
        .mem_ram_en        (mem_ram_en),
        .stall             (stall),
        .ex_done           (ex_done),
        .ex_busy           (ex_busy),
        .stall_cycles      (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Inputs for this cycle are already applied; check, then move to the next cycle
    task automatic step(input logic [5:0] es, input logic ed, input logic eb, input string tag);
        #1;
        chk({tag, ".stall"}, 32'(stall), 32'(es));
        chk({tag, ".done"},  32'(ex_done), 32'(ed));
        chk({tag, ".busy"},  32'(ex_busy), 32'(eb));
        chk({tag, ".cnt"},   32'(stall_cycles), 32'(exp_cnt % 16));
        if (es[0]) exp_cnt++;
        @(negedge clk);
    endtask

    task automatic clear_hazard();
        id_read_en_1 = 0; id_read_addr_1 = 0;
        id_read_en_2 = 0; id_read_addr_2 = 0;
        ex_ram_read_flag = 0; ex_write_reg_en = 0; ex_write_reg_addr = 0;
    endtask

    task automatic set_load(input logic [4:0] dst);
        ex_ram_read_flag = 1; ex_write_reg_en = 1; ex_write_reg_addr = dst;
    endtask

    initial begin
        rst = 1;
        clear_hazard();
        ex_start = 0; ex_cycles = 0;
        mem_ram_en = 1; mem_ram_ready = 0;   // MEM stall pending, masked by reset
        step(6'b000000, 0, 0, "reset");
        rst = 0; mem_ram_en = 0;
        step(6'b000000, 0, 0, "idle");

        // Load-use on port 2, then bubble clears it
        set_load(5'd5); id_read_en_2 = 1; id_read_addr_2 = 5'd5;
        step(6'b000111, 0, 0, "lu_p2");
        ex_ram_read_flag = 0; ex_write_reg_en = 0;
        step(6'b000000, 0, 0, "lu_bubble");
        // Destination r0 never stalls
        clear_hazard(); set_load(5'd0); id_read_en_1 = 1;
        step(6'b000000, 0, 0, "lu_r0");
        // Port 1 match only counts when the read is enabled
        clear_hazard(); set_load(5'd7); id_read_addr_1 = 5'd7;
        step(6'b000000, 0, 0, "lu_p1_off");
        id_read_en_1 = 1;
        step(6'b000111, 0, 0, "lu_p1");
        clear_hazard();

        // Multi-cycle N=4: stalled 4 cycles, done on the 5th
        ex_start = 1; ex_cycles = 5'd4;
        step(6'b001111, 0, 0, "mc4_t0");
        ex_start = 0;
        step(6'b001111, 0, 1, "mc4_t1");
        step(6'b001111, 0, 1, "mc4_t2");
        step(6'b001111, 0, 1, "mc4_t3");
        step(6'b000000, 1, 1, "mc4_done");
        step(6'b000000, 0, 0, "mc4_idle");

        // N=1
        ex_start = 1; ex_cycles = 5'd1;
        step(6'b001111, 0, 0, "mc1_t0");
        ex_start = 0;
        step(6'b000000, 1, 1, "mc1_done");
        step(6'b000000, 0, 0, "mc1_idle");

        // N=0 is single-cycle: no stall, no done
        ex_start = 1; ex_cycles = 5'd0;
        step(6'b000000, 0, 0, "mc0_t0");
        ex_start = 0;
        step(6'b000000, 0, 0, "mc0_t1");

        // MEM stall during BUSY: count continues; DONE holds until RAM ready
        ex_start = 1; ex_cycles = 5'd6;
        step(6'b001111, 0, 0, "mp_t0");
        ex_start = 0; mem_ram_en = 1; mem_ram_ready = 0;
        step(6'b011111, 0, 1, "mp_t1");
        step(6'b011111, 0, 1, "mp_t2");
        step(6'b011111, 0, 1, "mp_t3");
        mem_ram_ready = 1;
        step(6'b001111, 0, 1, "mp_t4");
        step(6'b001111, 0, 1, "mp_t5");
        mem_ram_ready = 0;
        step(6'b011111, 1, 1, "mp_hold1");
        step(6'b011111, 1, 1, "mp_hold2");
        mem_ram_ready = 1;
        step(6'b000000, 1, 1, "mp_release");
        mem_ram_en = 0;
        step(6'b000000, 0, 0, "mp_idle");

        // Load-use together with ex_start: EX stall masks it until EX advances
        set_load(5'd9); id_read_en_1 = 1; id_read_addr_1 = 5'd9;
        ex_start = 1; ex_cycles = 5'd2;
        step(6'b001111, 0, 0, "sim_t0");
        ex_start = 0;
        step(6'b001111, 0, 1, "sim_t1");
        step(6'b000111, 1, 1, "sim_lu");
        clear_hazard();
        step(6'b000000, 0, 0, "sim_idle");

        // Reset while BUSY with cnt=7
        ex_start = 1; ex_cycles = 5'd9;
        step(6'b001111, 0, 0, "rm_t0");
        ex_start = 0;
        step(6'b001111, 0, 1, "rm_busy");
        #2;
        rst = 1;
        exp_cnt = 0;
        step(6'b000000, 0, 0, "rm_reset");
        rst = 0;
        ex_start = 1; ex_cycles = 5'd1;
        step(6'b001111, 0, 0, "rm_new_t0");
        ex_start = 0;
        step(6'b000000, 1, 1, "rm_new_done");
        step(6'b000000, 0, 0, "rm_new_idle");

        // Counter wrap: 1 stalled cycle so far, 16 more gives 17 -> 1
        mem_ram_en = 1; mem_ram_ready = 0;
        for (int i = 0; i < 16; i++) begin
            step(6'b011111, 0, 0, "wrap_mem");
        end
        mem_ram_en = 0;
        #1;
        chk("wrap_final", 32'(stall_cycles), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall controller that drives the stall_current_stage / stall_next_stage pairs of every pipeline register (PC, IF_ID, ID_EX, EX_MEM, MEM_WB). It merges three stall sources into one monotone stall vector: load-use hazards detected between the ID and EX stages, multi-cycle EX operations, and a not-ready RAM in MEM. It sits beside the datapath. Stage k's register takes stall[k] as stall_current_stage and stall[k+1] as stall_next_stage.

## Interface
- EX_CNT_WIDTH, 5, width of the multi-cycle length field (1..31 cycles)
- PERF_CNT_WIDTH, 32, width of the stall-cycle performance counter
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- id_read_en_1  in  1  ID reads source register 1
- id_read_addr_1  in  `REG_ADDR_BUS_WIDTH  ID source register 1
- id_read_en_2  in  1  ID reads source register 2
- id_read_addr_2  in  `REG_ADDR_BUS_WIDTH  ID source register 2
- ex_ram_read_flag  in  1  instruction in EX is a load
- ex_write_reg_en  in  1  EX instruction writes a register
- ex_write_reg_addr  in  `REG_ADDR_BUS_WIDTH  EX destination register
- ex_start  in  1  EX begins a multi-cycle operation
- ex_cycles  in  EX_CNT_WIDTH  length N of that operation
- mem_ram_ready  in  1  RAM access in MEM completes this cycle
- mem_ram_en  in  1  MEM stage holds a RAM access
- stall  out  `STALL_BUS_WIDTH (6)  per-stage stall; bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
- ex_done  out  1  multi-cycle result is valid in EX this cycle
- ex_busy  out  1  multi-cycle FSM is not IDLE
- stall_cycles  out  PERF_CNT_WIDTH  count of cycles with stall[0]=1

## Operation
- The load-use condition is ex_ram_read_flag & ex_write_reg_en & ex_write_reg_addr≠0 & ((id_read_en_1 & addr_1 match) | (id_read_en_2 & addr_2 match)). It is combinational.
- The MEM stall condition is mem_ram_en & ~mem_ram_ready.
- The EX stall condition is (IDLE & ex_start & ex_cycles≠0) | BUSY.
- The stall vector uses fixed priority:
  - MEM stall → 6'b011111
  - else EX stall → 6'b001111
  - else load-use → 6'b000111
  - else 6'b000000
- stall[5] is always 0, and the vector is always monotone, so a bubble is inserted exactly at the first unstalled stage.
- The multi-cycle FSM has three states: IDLE, BUSY and DONE. It has a counter cnt of EX_CNT_WIDTH bits.
  - IDLE: ex_start with N=0 is ignored, because the operation is single-cycle. With ex_start and N=1, go to DONE. With ex_start and N≥2, go to BUSY and load cnt=N-2.
  - BUSY: if cnt=0, go to DONE; else decrement cnt.
  - DONE: ex_done=1 and the EX stall is released. Return to IDLE on a cycle where the MEM stall is 0; otherwise hold DONE.
- ex_start is ignored outside IDLE.
- The FSM advances during a MEM stall; the EX unit keeps computing while the stall is in effect.
- stall_cycles increments on every cycle with stall[0]=1 and wraps modulo 2^PERF_CNT_WIDTH.

## Timing
- Reset values: FSM IDLE, cnt=0, stall_cycles=0, ex_done=0, ex_busy=0.
- stall is combinational from the inputs and the state. While rst is high, stall=0.
- A multi-cycle operation with ex_start at cycle t and length N≥1 is handled as follows:
  - EX is stalled in cycles t..t+N-1, exactly N cycles.
  - ex_done=1 at cycle t+N.
  - The instruction leaves EX at the end of t+N, unless MEM is stalled.
- A load-use stall lasts exactly one cycle. The load then moves to MEM, and the bubble placed in EX clears the condition.
- Simultaneous events:
  - A MEM stall overrides the EX and load-use stalls in the same cycle.
  - A load-use stall during BUSY is masked by the EX stall. It re-evaluates once EX advances.
- Reset asserted mid-BUSY or in DONE returns the FSM to IDLE asynchronously. ex_done and ex_busy drop immediately, and the operation in progress is abandoned.

## Structure
- Add `STALL_BUS_WIDTH (6) and the stage index constants STALL_PC..STALL_WB to global_def.v.
- Use the existing `REG_ADDR_BUS / `REG_ADDR_BUS_WIDTH.
- The FSM state encodings are local parameters of the block.
- Split the multi-cycle FSM and counter into one sub-module, multicycle_tracker, with ports clk, rst, ex_start, ex_cycles, mem_stall, ex_stall, ex_done, ex_busy.
- The top level holds the hazard comparators, the priority mux and the performance counter.

## Test plan
- Load-use: load to r5 in EX, ID reads r5 on port 2 → stall=000111 for one cycle, then 000000. With destination r0 → no stall.
- Multi-cycle: ex_start with ex_cycles=4 at cycle 10 → stall=001111 in cycles 10–13, ex_done=1 at 14, ex_busy high 11–14. With ex_cycles=1 → one stall cycle, then ex_done. With ex_cycles=0 → no stall and no ex_done.
- MEM priority: mem_ram_en=1 with mem_ram_ready low for 3 cycles during BUSY → stall=011111 for those cycles. cnt still counts down. DONE holds until ready, then returns to IDLE.
- Simultaneous sources: load-use and ex_start in the same cycle → 001111. The load-use stall appears only after EX advances, if the hazard persists.
- Reset mid-operation: rst during BUSY with cnt=7 → immediately stall=0, ex_busy=0, stall_cycles=0. After release, a new ex_start is accepted.
- Counter wrap: with PERF_CNT_WIDTH=4, 17 stalled cycles → stall_cycles=1.
